enc_output_packer: RTL
======================

// Module: enc_output_packer
// PURPOSE
//  Downstream of the turbo encoder top. Captures the three serial output streams (xk, zk, zk')
//  for one code block: K systematic/parity bits plus 4 tail cycles. Packs each stream MSB-first
//  into bytes and writes the three byte lanes to the output FIFO together, in a single request.
//  The encoder cannot stall, so FIFO backpressure is reported as overflow. It is never a stall.
// PARAMETERS
//  K_SMALL   1056  block length when blk_size=0
//  K_LARGE   6144  block length when blk_size=1
//  TAIL_LEN  4     tail cycles appended after K bits
//  WORD_W    8     packed word width per lane
// PORTS
//  clock         in   1        system clock
//  reset         in   1        reset, asynchronous, active-high
//  blk_start     in   1        1-cycle pulse; begins a block; first bit_valid may come the next cycle
//  blk_size      in   1        sampled on blk_start: 0=K_SMALL, 1=K_LARGE
//  bit_valid     in   1        xk_in/zk_in/zkp_in carry a valid bit this cycle
//  xk_in         in   1        systematic bit (or tail bit)
//  zk_in         in   1        parity bit from encoder 1
//  zkp_in        in   1        parity bit from encoder 2
//  out_fifo_full in   1        output FIFO cannot accept a write this cycle
//  out_wreq      out  1        write strobe, one cycle per packed word
//  out_xk        out  WORD_W   packed xk byte
//  out_zk        out  WORD_W   packed zk byte
//  out_zkp       out  WORD_W   packed zk' byte
//  busy          out  1        state != IDLE
//  blk_done      out  1        1-cycle pulse, one cycle after the last word write of a block
//  blk_aborted   out  1        1-cycle pulse when blk_start restarts an unfinished block
//  overflow      out  1        sticky: a word was dropped because out_fifo_full was set
//  bit_count     out  13       bits accepted in the current block (0..K+TAIL_LEN)
// BEHAVIOUR
//  Reset (async): all outputs 0, state IDLE, shift registers 0, bit_count 0.
//  FSM: IDLE -> COLLECT on blk_start, latching N = K + TAIL_LEN (1060 or 6148).
//   COLLECT: each bit_valid shifts one bit into each lane register (first bit lands in MSB)
//   and increments bit_count.
//   COLLECT -> FLUSH when the accepted bit makes bit_count == N.
//   FLUSH: emits the final partial word if one is pending, else goes straight on. Then -> DONE.
//   DONE: pulses blk_done for one cycle, then -> IDLE.
//  Word emission:
//   - The 8th bit of a word accepted at cycle t gives out_wreq=1 at t+1.
//   - The out_* bytes are registered and held until the next write.
//   - Final word: N mod 8 = 4 for both sizes. The 4 valid bits sit in [7:4]; [3:0] = 0.
//   - That word is written in the cycle after entering FLUSH.
//   - Words per block: 133 (K=1056), 769 (K=6144).
//  Backpressure: if out_fifo_full=1 in the cycle out_wreq would assert:
//   - out_wreq stays 0 and the word is dropped; overflow is set.
//   - Counting continues regardless.
//  overflow clears on reset or on an accepted blk_start.
//  bit_valid in IDLE, FLUSH or DONE: ignored, no count.
//  bit_valid above N is impossible by construction, because the FSM leaves COLLECT at N.
//  blk_start in COLLECT/FLUSH/DONE:
//   - Current block abandoned; partial word discarded, no write.
//   - blk_aborted pulses; new size latched; bit_count=0; state COLLECT.
//  blk_start together with bit_valid in the same cycle: the bit is ignored (belongs to no block).
//  Word completion and FLUSH entry in the same cycle (not reachable, since N mod 8 = 4):
//   the complete word is written first.
//  Reset mid-block: immediate return to IDLE with no writes and no done pulse.
// TESTING
//  1. blk_size=0, 1060 valid bits (xk=1, zk=0, zkp alternating 1,0)
//     -> 133 writes; words 0..131 = FF/00/AA; last = F0/00/A0; blk_done 1 cycle after write 133.
//  2. blk_size=1, 6148 bits of a PRBS-7 pattern -> 769 writes matching the reference packer;
//     overflow stays 0.
//  3. K=1056 with bit_valid gapped 1-in-3
//     -> same 133 words as test 1; each out_wreq exactly 1 cycle after the 8th bit.
//  4. out_fifo_full=1 for words 10-11 -> 131 writes, those 2 words missing, overflow=1.
//     Next blk_start clears overflow.
//  5. blk_start at bit_count=500 -> blk_aborted pulse, no partial write, bit_count=0.
//     A fresh 1060-bit block then completes normally.
//  6. reset asserted at bit_count=300, then released -> all outputs 0, IDLE;
//     no blk_done; next block is correct.

Source files
------------

// File: rtl/enc_output_packer.sv
`default_nettype none
// ============================================================================
//  Module      : enc_output_packer
//  Description : Captures the xk / zk / zk' serial streams of one turbo-code
//                block (K bits plus tail), packs each stream MSB-first into
//                WORD_W-bit words and writes the three lanes to the output
//                FIFO together. FIFO backpressure drops the word and raises a
//                sticky overflow flag; the encoder is never stalled.
//  Revision    : 1.0 - initial release
// ============================================================================
module enc_output_packer #(
    parameter int K_SMALL  = 1056,
    parameter int K_LARGE  = 6144,
    parameter int TAIL_LEN = 4,
    parameter int WORD_W   = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              blk_start,
    input  logic              blk_size,
    input  logic              bit_valid,
    input  logic              xk_in,
    input  logic              zk_in,
    input  logic              zkp_in,
    input  logic              out_fifo_full,
    output logic              out_wreq,
    output logic [WORD_W-1:0] out_xk,
    output logic [WORD_W-1:0] out_zk,
    output logic [WORD_W-1:0] out_zkp,
    output logic              busy,
    output logic              blk_done,
    output logic              blk_aborted,
    output logic              overflow,
    output logic [12:0]       bit_count
);

    localparam int          c_FILL_W  = $clog2(WORD_W);
    localparam logic [12:0] c_N_SMALL = 13'(K_SMALL + TAIL_LEN);
    localparam logic [12:0] c_N_LARGE = 13'(K_LARGE + TAIL_LEN);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_FLUSH   = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic [12:0]         r_n;
    logic [12:0]         r_bit_count;
    logic [WORD_W-1:0]   r_sh_xk;
    logic [WORD_W-1:0]   r_sh_zk;
    logic [WORD_W-1:0]   r_sh_zkp;
    logic [WORD_W-1:0]   r_out_xk;
    logic [WORD_W-1:0]   r_out_zk;
    logic [WORD_W-1:0]   r_out_zkp;
    logic                r_wpend;
    logic                r_blk_done;
    logic                r_blk_aborted;
    logic                r_overflow;

    logic                w_accept;
    logic                w_last;
    logic                w_word_done;
    logic                w_partial;
    logic [c_FILL_W-1:0] w_fill;
    logic [c_FILL_W:0]   w_shamt;
    logic [12:0]         w_count_inc;

    // Bits already held in the current word; a block always starts word-aligned.
    assign w_fill      = r_bit_count[c_FILL_W-1:0];
    // A bit arriving with blk_start belongs to no block and is ignored.
    assign w_accept    = (r_state == S_COLLECT) && bit_valid && !blk_start;
    assign w_count_inc = r_bit_count + 13'd1;
    assign w_last      = w_accept && (w_count_inc == r_n);
    assign w_word_done = w_accept && (w_fill == c_FILL_W'(WORD_W - 1));
    // Final partial word, left-justified so the valid bits sit in the MSBs.
    assign w_partial   = (r_state == S_FLUSH) && !blk_start && (w_fill != '0);
    assign w_shamt     = (c_FILL_W + 1)'(WORD_W) - {1'b0, w_fill};

    // The write strobe is qualified by the FIFO state in the write cycle itself.
    assign out_wreq    = r_wpend && !out_fifo_full;
    assign out_xk      = r_out_xk;
    assign out_zk      = r_out_zk;
    assign out_zkp     = r_out_zkp;
    assign busy        = (r_state != S_IDLE);
    assign blk_done    = r_blk_done;
    assign blk_aborted = r_blk_aborted;
    assign overflow    = r_overflow;
    assign bit_count   = r_bit_count;

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; blk_start always (re)starts collection.
    always_comb begin
        w_state_nxt = r_state;
        if (blk_start) begin
            w_state_nxt = S_COLLECT;
        end else begin
            case (r_state)
                S_IDLE:    w_state_nxt = S_IDLE;
                S_COLLECT: if (w_last) w_state_nxt = S_FLUSH;
                S_FLUSH:   w_state_nxt = S_DONE;
                S_DONE:    w_state_nxt = S_IDLE;
                default:   w_state_nxt = S_IDLE;
            endcase
        end
    end

    // Bit collection, word packing, write request and status flags.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_n           <= '0;
            r_bit_count   <= '0;
            r_sh_xk       <= '0;
            r_sh_zk       <= '0;
            r_sh_zkp      <= '0;
            r_out_xk      <= '0;
            r_out_zk      <= '0;
            r_out_zkp     <= '0;
            r_wpend       <= 1'b0;
            r_blk_done    <= 1'b0;
            r_blk_aborted <= 1'b0;
            r_overflow    <= 1'b0;
        end else begin
            r_wpend       <= 1'b0;
            r_blk_done    <= 1'b0;
            r_blk_aborted <= 1'b0;

            if (blk_start) begin
                // New block: any unfinished block and its partial word are discarded.
                r_n           <= blk_size ? c_N_LARGE : c_N_SMALL;
                r_bit_count   <= '0;
                r_sh_xk       <= '0;
                r_sh_zk       <= '0;
                r_sh_zkp      <= '0;
                r_blk_aborted <= (r_state != S_IDLE);
                r_overflow    <= 1'b0;
            end else begin
                if (w_accept) begin
                    r_bit_count <= w_count_inc;
                    r_sh_xk     <= {r_sh_xk[WORD_W-2:0], xk_in};
                    r_sh_zk     <= {r_sh_zk[WORD_W-2:0], zk_in};
                    r_sh_zkp    <= {r_sh_zkp[WORD_W-2:0], zkp_in};
                    if (w_word_done) begin
                        r_out_xk  <= {r_sh_xk[WORD_W-2:0], xk_in};
                        r_out_zk  <= {r_sh_zk[WORD_W-2:0], zk_in};
                        r_out_zkp <= {r_sh_zkp[WORD_W-2:0], zkp_in};
                        r_wpend   <= 1'b1;
                    end
                end
                if (w_partial) begin
                    r_out_xk  <= r_sh_xk << w_shamt;
                    r_out_zk  <= r_sh_zk << w_shamt;
                    r_out_zkp <= r_sh_zkp << w_shamt;
                    r_wpend   <= 1'b1;
                end
                if (r_state == S_DONE) begin
                    r_blk_done <= 1'b1;
                end
            end

            // A word refused by the FIFO is lost; remember that it happened.
            if (r_wpend && out_fifo_full) begin
                r_overflow <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire
